alu32_result_stage: RTL and testbench
=====================================

Name: alu32_result_stage

Overview:
Downstream stage of the 32-bit ALU. It captures each ALU result (X, C_out) together with the Mode that produced it. It derives status flags at capture time and buffers entries in a small FIFO with valid/ready handshakes on both sides, so the ALU's consumer can stall without losing results. It also keeps a saturating count of carry-out events for debug and test.

Parameters:
DEPTH, 2, FIFO entries; power of two, 2..16
CNT_W, 8, width of carry-event counter

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_n  input  1  synchronous active-low reset, sampled on rising CLK
In_valid  input  1  ALU result on X/C_out/Mode is valid
In_ready  output  1  stage can accept a result this cycle
X  input  32  ALU result word
C_out  input  1  ALU carry out
Mode  input  3  ALU operation code that produced X
Out_valid  output  1  head entry valid
Out_ready  input  1  consumer accepts head entry
Out_X  output  32  head entry result
Out_mode  output  3  head entry Mode
Out_flags  output  4  head entry flags {C, Z, N, P}
Level  output  clog2(DEPTH)+1  number of stored entries
Carry_cnt  output  CNT_W  saturating count of accepted results with C_out=1
Clr_cnt  input  1  synchronous clear of Carry_cnt

Behaviour:
- Reset (RST_n=0 at rising CLK):
  - FIFO emptied; pointers and Level = 0; Carry_cnt = 0.
  - Out_valid = 0, In_ready = 1, Out_X = 0, Out_mode = 0, Out_flags = 0.
  - Reset mid-operation discards all stored entries; a push or pop presented in the reset cycle is ignored.
- Push: when In_valid && In_ready at rising CLK, write {X, Mode, flags} at the write pointer.
- Flags computed from the captured inputs at push time:
  - C = C_out
  - Z = (X == 0)
  - N = X[31]
  - P = XOR-reduce of X (1 = odd number of ones)
- Pop: when Out_valid && Out_ready at rising CLK, advance the read pointer.
- Pointers wrap modulo DEPTH.
- In_ready = (Level != DEPTH), decoded from registered state only; no combinational path from Out_ready.
- Out_valid = (Level != 0).
- Out_X/Out_mode/Out_flags show the head entry; all are 0 when empty.
- Latency: a result accepted at edge k is visible on Out_* after edge k; the earliest pop is at edge k+1. No same-cycle pass-through.
- Simultaneous push and pop (non-empty, not full): both occur, Level unchanged, order preserved.
- Full: In_ready = 0, so no push. A pop in that cycle still occurs and In_ready returns to 1 the next cycle.
- Empty: Out_valid = 0, so no pop. A push in that cycle makes Out_valid = 1 the next cycle.
- Outputs must hold steady while Out_valid && !Out_ready.
- Carry_cnt update per rising CLK:
  - Clr_cnt = 1: Carry_cnt = 0. Clear has priority, even if a carry push occurs that cycle.
  - Otherwise, on a push with C_out = 1: increment, saturating at 2^CNT_W - 1.
  - Pops never affect Carry_cnt.
- Inputs X/C_out/Mode are don't-care when In_valid = 0.

Test Plan:
- Reset, then single push X=32'h0001_0000, C_out=0, Mode=3'b000, Out_ready=1 -> next cycle Out_valid=1, Out_X=32'h0001_0000, Out_flags=4'b0001; popped next edge, Level back to 0.
- Push X=0, C_out=1, Mode=3'b000 -> Out_flags=4'b1100, Carry_cnt=1. Push X=32'h8000_0003 -> Out_flags=4'b0011 (N=1, odd parity).
- Hold Out_ready=0, push 3 results with DEPTH=2 -> Level=2, In_ready=0 after the second push; third result not accepted. Raise Out_ready -> entries drain in order, In_ready=1 one cycle after the first pop.
- Level=1, continuous In_valid=1 and Out_ready=1 for 10 cycles with incrementing X -> Level stays 1, Out_X sequence equals the input sequence delayed by one entry, no loss or duplication.
- 260 pushes with C_out=1 (CNT_W=8) -> Carry_cnt saturates at 255. Clr_cnt=1 in the same cycle as a C_out=1 push -> Carry_cnt=0.
- Fill to Level=2, assert RST_n=0 for one cycle while In_valid=1 and Out_ready=1 -> Level=0, Out_valid=0, In_ready=1, Carry_cnt=0, Out_X=0.

Source files
------------

// File: rtl/alu32_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and the result consumer.
// A transfer happens on a rising CLK where valid && ready; the sender holds valid and payload steady until then.
interface alu32_result_stage_if;
   logic        In_valid;
   logic        In_ready;
   logic [31:0] X;
   logic        C_out;
   logic [2:0]  Mode;
   logic        Out_valid;
   logic        Out_ready;
   logic [31:0] Out_X;
   logic [2:0]  Out_mode;
   logic [3:0]  Out_flags;

   modport master (
      output In_valid, X, C_out, Mode, Out_ready,
      input  In_ready, Out_valid, Out_X, Out_mode, Out_flags
   );

   modport slave (
      input  In_valid, X, C_out, Mode, Out_ready,
      output In_ready, Out_valid, Out_X, Out_mode, Out_flags
   );
endinterface

// File: rtl/alu32_result_stage.sv
// ALU result stage: captures {X, Mode, flags} into a small FIFO and counts carry-out events.
// In_ready depends only on registered state, so a stalled consumer never loops back into the ALU.
module alu32_result_stage #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic                    CLK,
   input  logic                    RST_n,
   alu32_result_stage_if.slave     bus,
   input  logic                    Clr_cnt,
   output logic [$clog2(DEPTH):0]  Level,
   output logic [CNT_W-1:0]        Carry_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0]    FULL_LEVEL = LW'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   logic [31:0]      mem_x     [DEPTH];
   logic [2:0]       mem_mode  [DEPTH];
   logic [3:0]       mem_flags [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic [CNT_W-1:0] carry_cnt_q;
   logic             in_ready;
   logic             out_valid;
   logic             push;
   logic             pop;
   logic [3:0]       in_flags;

   assign in_ready  = (level_q != FULL_LEVEL);
   assign out_valid = (level_q != '0);
   assign push      = bus.In_valid && in_ready;
   assign pop       = out_valid && bus.Out_ready;

   // Flags {C, Z, N, P}, P = 1 for an odd number of ones in X.
   assign in_flags = {bus.C_out, (bus.X == 32'd0), bus.X[31], ^bus.X};

   // Storage needs no reset: the read side is masked to zero whenever Level is 0.
   always_ff @(posedge CLK) begin
      if (RST_n && push) begin
         mem_x[wr_ptr_q]     <= bus.X;
         mem_mode[wr_ptr_q]  <= bus.Mode;
         mem_flags[wr_ptr_q] <= in_flags;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      level_q <= level_q + LW'(1);
         else if (pop && !push) level_q <= level_q - LW'(1);
      end
   end

   // Clear wins over a simultaneous carry push.
   always_ff @(posedge CLK) begin
      if (!RST_n || Clr_cnt) begin
         carry_cnt_q <= '0;
      end else if (push && bus.C_out && (carry_cnt_q != CNT_MAX)) begin
         carry_cnt_q <= carry_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      bus.Out_X     = 32'd0;
      bus.Out_mode  = 3'd0;
      bus.Out_flags = 4'd0;
      if (out_valid) begin
         bus.Out_X     = mem_x[rd_ptr_q];
         bus.Out_mode  = mem_mode[rd_ptr_q];
         bus.Out_flags = mem_flags[rd_ptr_q];
      end
   end

   assign bus.In_ready  = in_ready;
   assign bus.Out_valid = out_valid;
   assign Level         = level_q;
   assign Carry_cnt     = carry_cnt_q;
endmodule

// File: tb/tb_alu32_result_stage.sv
// Bench for alu32_result_stage: flag vector table, hand-written corner sequences and random traffic
// checked every cycle against a queue model of the FIFO and an integer model of the carry counter.
module tb_alu32_result_stage;
   localparam int DEPTH = 2;
   localparam int CNT_W = 8;
   localparam int CNT_MAX = 255;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr_cnt;
   logic [2:0]       level;
   logic [CNT_W-1:0] carry_cnt;

   alu32_result_stage_if bus();

   alu32_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLK       (clk),
      .RST_n     (rst_n),
      .bus       (bus),
      .Clr_cnt   (clr_cnt),
      .Level     (level),
      .Carry_cnt (carry_cnt)
   );

   always #5 clk = ~clk;

   // Model state: entries packed as {x[31:0], mode[2:0], flags[3:0]}.
   logic [38:0] exp_q[$];
   int          model_cnt = 0;
   int          n_total = 0;
   int          n_pass = 0;

   typedef struct {
      logic [31:0] x;
      logic        c;
      logic [2:0]  mode;
      logic [3:0]  flags;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [3:0] ref_flags(logic [31:0] x, logic c);
      logic [3:0] f;
      f[3] = c;
      f[2] = (x == 32'd0);
      f[1] = (x >= 32'h8000_0000);
      f[0] = (($countones(x) % 2) == 1);
      return f;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic drive(logic v, logic [31:0] x, logic c, logic [2:0] mode, logic rdy);
      bus.In_valid  = v;
      bus.X         = x;
      bus.C_out     = c;
      bus.Mode      = mode;
      bus.Out_ready = rdy;
   endtask

   task automatic check_outputs();
      logic [38:0] head;
      head = (exp_q.size() != 0) ? exp_q[0] : 39'd0;
      chk("out_valid", 64'(bus.Out_valid), 64'(exp_q.size() != 0));
      chk("in_ready",  64'(bus.In_ready),  64'(exp_q.size() < DEPTH));
      chk("level",     64'(level),         64'(exp_q.size()));
      chk("out_x",     64'(bus.Out_X),     64'(head[38:7]));
      chk("out_mode",  64'(bus.Out_mode),  64'(head[6:4]));
      chk("out_flags", 64'(bus.Out_flags), 64'(head[3:0]));
      chk("carry_cnt", 64'(carry_cnt),     64'(model_cnt));
   endtask

   // One clock: check at the falling edge, predict from the inputs, advance the model at the rising edge.
   task automatic step();
      bit          push;
      bit          pop;
      bit          c;
      bit          clr;
      bit          rst;
      logic [38:0] e;
      @(negedge clk);
      check_outputs();
      rst  = !rst_n;
      clr  = clr_cnt;
      c    = bus.C_out;
      push = bus.In_valid && (exp_q.size() < DEPTH);
      pop  = bus.Out_ready && (exp_q.size() > 0);
      e    = {bus.X, bus.Mode, ref_flags(bus.X, bus.C_out)};
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         model_cnt = 0;
      end else begin
         if (pop)  void'(exp_q.pop_front());
         if (push) exp_q.push_back(e);
         if (clr) model_cnt = 0;
         else if (push && c && model_cnt < CNT_MAX) model_cnt++;
      end
      #1;
   endtask

   initial begin
      vecs[0] = '{32'h0001_0000, 1'b0, 3'b000, 4'b0001};
      vecs[1] = '{32'h0000_0000, 1'b1, 3'b000, 4'b1100};
      vecs[2] = '{32'h8000_0003, 1'b0, 3'b001, 4'b0011};
      vecs[3] = '{32'hFFFF_FFFF, 1'b1, 3'b111, 4'b1010};
      vecs[4] = '{32'h7FFF_FFFF, 1'b0, 3'b101, 4'b0001};
      vecs[5] = '{32'h0000_0003, 1'b1, 3'b010, 4'b1000};

      rst_n   = 1'b0;
      clr_cnt = 1'b0;
      drive(1'b0, 32'd0, 1'b0, 3'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      step();
      rst_n = 1'b1;

      // Flag table: push each vector alone, compare against the tabulated flags, then pop it.
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].x, vecs[i].c, vecs[i].mode, 1'b0);
         step();
         chk("tbl_flags", 64'(bus.Out_flags), 64'(vecs[i].flags));
         chk("tbl_x",     64'(bus.Out_X),     64'(vecs[i].x));
         chk("tbl_mode",  64'(bus.Out_mode),  64'(vecs[i].mode));
         drive(1'b0, 32'd0, 1'b0, 3'd0, 1'b1);
         step();
         chk("tbl_popped_level", 64'(level), 64'd0);
      end
      chk("tbl_carry_cnt", 64'(carry_cnt), 64'd3);

      // Fill while stalled; the third offer must be refused.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 3'(i), 1'b0);
         step();
      end
      chk("full_level",    64'(level),        64'd2);
      chk("full_in_ready", 64'(bus.In_ready), 64'd0);
      drive(1'b0, 32'd0, 1'b0, 3'd0, 1'b1);
      step();
      chk("drain_in_ready", 64'(bus.In_ready), 64'd1);
      chk("drain_order",    64'(bus.Out_X),    64'h0000_0000_A000_0001);
      step();
      chk("drain_empty", 64'(bus.Out_valid), 64'd0);

      // Streaming at Level 1: one entry ahead, then push and pop every cycle.
      drive(1'b1, 32'h0000_0100, 1'b0, 3'd3, 1'b0);
      step();
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 32'h0000_0100 + 32'(i), 1'b0, 3'd3, 1'b1);
         step();
         chk("stream_level", 64'(level),     64'd1);
         chk("stream_x",     64'(bus.Out_X), 64'(32'h0000_0100 + 32'(i)));
      end

      // Carry saturation, then clear racing a carry push.
      for (int i = 0; i < 260; i++) begin
         drive(1'b1, 32'(i), 1'b1, 3'd1, 1'b1);
         step();
      end
      chk("sat_carry_cnt", 64'(carry_cnt), 64'(CNT_MAX));
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      chk("clr_priority", 64'(carry_cnt), 64'd0);

      // Fill to 2, then reset with push and pop both offered.
      drive(1'b1, 32'h1234_5678, 1'b1, 3'd4, 1'b0);
      step();
      step();
      chk("pre_rst_level", 64'(level), 64'd2);
      drive(1'b1, 32'hDEAD_BEEF, 1'b1, 3'd6, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(1'b0, 32'd0, 1'b0, 3'd0, 1'b0);
      chk("rst_level",     64'(level),         64'd0);
      chk("rst_out_valid", 64'(bus.Out_valid), 64'd0);
      chk("rst_in_ready",  64'(bus.In_ready),  64'd1);
      chk("rst_carry_cnt", 64'(carry_cnt),     64'd0);
      chk("rst_out_x",     64'(bus.Out_X),     64'd0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom()),
               1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)),
               1'($urandom_range(0, 3) != 0));
         clr_cnt = ($urandom_range(0, 31) == 0);
         rst_n   = ($urandom_range(0, 99) != 0);
         step();
      end
      rst_n   = 1'b1;
      clr_cnt = 1'b0;
      drive(1'b0, 32'd0, 1'b0, 3'd0, 1'b1);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
